// File: rtl/bilinear_src_fetch_if.sv
// Coordinate, source-memory and neighbourhood-output signals of the bilinear source fetch unit.
// master: the fetch unit itself; slave: the surrounding interpolator, memory and control.
interface bilinear_src_fetch_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 16,
  parameter int ADDR_WIDTH  = 20
);
  logic                   start_i;
  logic                   hold_i;
  logic [INDEX_WIDTH-1:0] src_width_i;
  logic [INDEX_WIDTH-1:0] src_height_i;
  logic [INDEX_WIDTH-1:0] dest_width_i;
  logic [INDEX_WIDTH-1:0] dest_height_i;
  logic [INDEX_WIDTH-1:0] destx_o;
  logic [INDEX_WIDTH-1:0] desty_o;
  logic [INDEX_WIDTH-1:0] srcx_int_i;
  logic [INDEX_WIDTH-1:0] srcy_int_i;
  logic                   rd_en_o;
  logic [ADDR_WIDTH-1:0]  rd_addr00_o;
  logic [ADDR_WIDTH-1:0]  rd_addr01_o;
  logic [ADDR_WIDTH-1:0]  rd_addr10_o;
  logic [ADDR_WIDTH-1:0]  rd_addr11_o;
  logic [DATA_WIDTH-1:0]  rd_data00_i;
  logic [DATA_WIDTH-1:0]  rd_data01_i;
  logic [DATA_WIDTH-1:0]  rd_data10_i;
  logic [DATA_WIDTH-1:0]  rd_data11_i;
  logic                   tvalid_o;
  logic [DATA_WIDTH-1:0]  tdata00_o;
  logic [DATA_WIDTH-1:0]  tdata01_o;
  logic [DATA_WIDTH-1:0]  tdata10_o;
  logic [DATA_WIDTH-1:0]  tdata11_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    input  start_i, hold_i, src_width_i, src_height_i, dest_width_i, dest_height_i,
    input  srcx_int_i, srcy_int_i,
    input  rd_data00_i, rd_data01_i, rd_data10_i, rd_data11_i,
    output destx_o, desty_o,
    output rd_en_o, rd_addr00_o, rd_addr01_o, rd_addr10_o, rd_addr11_o,
    output tvalid_o, tdata00_o, tdata01_o, tdata10_o, tdata11_o,
    output busy_o, done_o
  );

  modport slave (
    output start_i, hold_i, src_width_i, src_height_i, dest_width_i, dest_height_i,
    output srcx_int_i, srcy_int_i,
    output rd_data00_i, rd_data01_i, rd_data10_i, rd_data11_i,
    input  destx_o, desty_o,
    input  rd_en_o, rd_addr00_o, rd_addr01_o, rd_addr10_o, rd_addr11_o,
    input  tvalid_o, tdata00_o, tdata01_o, tdata10_o, tdata11_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/bilinear_src_fetch.sv
// Bilinear scaler feed: raster-issues destination coordinates, fetches the clamped 2x2
// source neighbourhood through four read ports and returns it with an aligned valid strobe.
module bilinear_src_fetch #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 16,
  parameter int ADDR_WIDTH  = 20,
  parameter int SRC_LAT     = 2,
  parameter int MEM_LAT     = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  bilinear_src_fetch_if.master bus
);
  localparam int DEPTH = SRC_LAT + MEM_LAT + 2;
  localparam int PW    = 2 * INDEX_WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]             state;
  logic [INDEX_WIDTH-1:0] src_w;
  logic [INDEX_WIDTH-1:0] src_h;
  logic [INDEX_WIDTH-1:0] dst_w;
  logic [INDEX_WIDTH-1:0] dst_h;
  logic [DEPTH-1:0]       vld;
  logic                   issue;
  logic                   last_x;
  logic                   last_y;
  logic                   src_take;
  logic                   data_take;

  assign issue     = (state == ISSUE) && !bus.hold_i;
  assign last_x    = (bus.destx_o == dst_w - INDEX_WIDTH'(1));
  assign last_y    = (bus.desty_o == dst_h - INDEX_WIDTH'(1));
  assign data_take = vld[DEPTH-2];

  // vld[k] marks an issue made k+1 cycles ago; the interpolator answer for that
  // issue arrives when it sits at stage SRC_LAT-1 (or immediately for zero latency).
  if (SRC_LAT == 0) begin : g_take_now
    assign src_take = issue;
  end else begin : g_take_pipe
    assign src_take = vld[SRC_LAT-1];
  end

  assign bus.rd_en_o  = vld[SRC_LAT];
  assign bus.tvalid_o = vld[DEPTH-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld <= '0;
    end else begin
      vld <= {vld[DEPTH-2:0], issue};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      src_w       <= '0;
      src_h       <= '0;
      dst_w       <= '0;
      dst_h       <= '0;
      bus.destx_o <= '0;
      bus.desty_o <= '0;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            src_w       <= bus.src_width_i;
            src_h       <= bus.src_height_i;
            dst_w       <= bus.dest_width_i;
            dst_h       <= bus.dest_height_i;
            bus.destx_o <= '0;
            bus.desty_o <= '0;
            bus.busy_o  <= 1'b1;
            if (bus.dest_width_i == '0 || bus.dest_height_i == '0) begin
              state <= FLUSH;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!bus.hold_i) begin
            if (last_x) begin
              bus.destx_o <= '0;
              bus.desty_o <= bus.desty_o + INDEX_WIDTH'(1);
              if (last_y) begin
                state <= FLUSH;
              end
            end else begin
              bus.destx_o <= bus.destx_o + INDEX_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          // Only the lower stages matter: the pipe is empty on the cycle done_o shows.
          if (vld[DEPTH-2:0] == '0) begin
            bus.done_o <= 1'b1;
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [INDEX_WIDTH-1:0] x_max;
  logic [INDEX_WIDTH-1:0] y_max;
  logic [INDEX_WIDTH-1:0] x0;
  logic [INDEX_WIDTH-1:0] x1;
  logic [INDEX_WIDTH-1:0] y0;
  logic [INDEX_WIDTH-1:0] y1;

  always_comb begin
    x_max = src_w - INDEX_WIDTH'(1);
    y_max = src_h - INDEX_WIDTH'(1);
    x0    = bus.srcx_int_i;
    x1    = bus.srcx_int_i + INDEX_WIDTH'(1);
    y0    = bus.srcy_int_i;
    y1    = bus.srcy_int_i + INDEX_WIDTH'(1);
    if (bus.srcx_int_i >= x_max) begin
      x0 = x_max;
      x1 = x_max;
    end
    if (bus.srcy_int_i >= y_max) begin
      y0 = y_max;
      y1 = y_max;
    end
  end

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [INDEX_WIDTH-1:0] y,
                                                    input logic [INDEX_WIDTH-1:0] x,
                                                    input logic [INDEX_WIDTH-1:0] w);
    logic [PW-1:0] full;
    full = PW'(y) * PW'(w) + PW'(x);
    return ADDR_WIDTH'(full);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.rd_addr00_o <= '0;
      bus.rd_addr01_o <= '0;
      bus.rd_addr10_o <= '0;
      bus.rd_addr11_o <= '0;
    end else if (src_take) begin
      bus.rd_addr00_o <= addr_of(y0, x0, src_w);
      bus.rd_addr01_o <= addr_of(y0, x1, src_w);
      bus.rd_addr10_o <= addr_of(y1, x0, src_w);
      bus.rd_addr11_o <= addr_of(y1, x1, src_w);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.tdata00_o <= '0;
      bus.tdata01_o <= '0;
      bus.tdata10_o <= '0;
      bus.tdata11_o <= '0;
    end else if (data_take) begin
      bus.tdata00_o <= bus.rd_data00_i;
      bus.tdata01_o <= bus.rd_data01_i;
      bus.tdata10_o <= bus.rd_data10_i;
      bus.tdata11_o <= bus.rd_data11_i;
    end
  end
endmodule

// File: tb/tb_bilinear_src_fetch.sv
// Self-checking bench for bilinear_src_fetch: interpolator and memory stand-ins, a
// frame-level reference scoreboard, a table of directed frames and randomized frames.
module tb_bilinear_src_fetch;
  localparam int DW = 8;
  localparam int IW = 16;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bilinear_src_fetch_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  bilinear_src_fetch #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .SRC_LAT(2), .MEM_LAT(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Interpolator stand-in: source coordinate as a function of destination coordinate.
  int m_sw, m_sh, m_dw, m_dh, m_mode;
  function automatic int interp(input int d, input int s, input int dd, input int mode);
    case (mode)
      0:       return 2 * d;
      1:       return 2 * d + 1;
      default: return (dd == 0) ? 0 : (d * s) / dd;
    endcase
  endfunction

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {4'b0, a[19:16]};
  endfunction

  logic [IW-1:0] px1, px2, py1, py2;
  always @(posedge clk) begin
    px1 <= IW'(interp(int'(bus.destx_o), m_sw, m_dw, m_mode));
    py1 <= IW'(interp(int'(bus.desty_o), m_sh, m_dh, m_mode));
    px2 <= px1;
    py2 <= py1;
  end
  assign bus.srcx_int_i = px2;
  assign bus.srcy_int_i = py2;

  always @(posedge clk) begin
    bus.rd_data00_i <= mem_val(bus.rd_addr00_o);
    bus.rd_data01_i <= mem_val(bus.rd_addr01_o);
    bus.rd_data10_i <= mem_val(bus.rd_addr10_o);
    bus.rd_data11_i <= mem_val(bus.rd_addr11_o);
  end

  // Reference: every destination pixel in raster order, clamped neighbourhood and pixels.
  logic [79:0] exp_rd[$];
  logic [31:0] exp_tv[$];
  task automatic build_expected();
    int sx, sy, x0, x1, y0, y1;
    logic [AW-1:0] a00, a01, a10, a11;
    exp_rd.delete();
    exp_tv.delete();
    for (int y = 0; y < m_dh; y++) begin
      for (int x = 0; x < m_dw; x++) begin
        sx = interp(x, m_sw, m_dw, m_mode);
        sy = interp(y, m_sh, m_dh, m_mode);
        x0 = (sx >= m_sw - 1) ? m_sw - 1 : sx;
        x1 = (sx >= m_sw - 1) ? m_sw - 1 : sx + 1;
        y0 = (sy >= m_sh - 1) ? m_sh - 1 : sy;
        y1 = (sy >= m_sh - 1) ? m_sh - 1 : sy + 1;
        a00 = AW'(y0 * m_sw + x0);
        a01 = AW'(y0 * m_sw + x1);
        a10 = AW'(y1 * m_sw + x0);
        a11 = AW'(y1 * m_sw + x1);
        exp_rd.push_back({a00, a01, a10, a11});
        exp_tv.push_back({mem_val(a00), mem_val(a01), mem_val(a10), mem_val(a11)});
      end
    end
  endtask

  int tv_count, rd_count, first_tv, last_tv, busy_cyc, done_count = 0;
  logic prev_busy = 1'b0;
  logic [31:0] got_tv[$];
  logic [79:0] e_rd;
  logic [31:0] e_tv, a_tv;

  always @(negedge clk) begin
    if (rst) begin
      exp_rd.delete();
      exp_tv.delete();
      prev_busy = 1'b0;
    end else begin
      if (bus.rd_en_o) begin
        rd_count++;
        if (exp_rd.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rd_en_extra: got rd_en=1 expected no read (cycle %0d)", cyc);
        end else begin
          e_rd = exp_rd.pop_front();
          check("rd_addrs", {bus.rd_addr00_o, bus.rd_addr01_o, bus.rd_addr10_o, bus.rd_addr11_o}, e_rd);
        end
      end
      if (bus.tvalid_o) begin
        if (tv_count == 0) first_tv = cyc;
        last_tv = cyc;
        tv_count++;
        a_tv = {bus.tdata00_o, bus.tdata01_o, bus.tdata10_o, bus.tdata11_o};
        got_tv.push_back(a_tv);
        if (exp_tv.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tvalid_extra: got tdata %0h expected no output (cycle %0d)", a_tv, cyc);
        end else begin
          e_tv = exp_tv.pop_front();
          check("tdata", a_tv, e_tv);
        end
      end
      if (bus.done_o) begin
        check("done_busy_low", bus.busy_o, 0);
        check("done_sb_empty", exp_tv.size(), 0);
        if (tv_count > 0) check("done_after_last_tvalid", cyc, last_tv + 1);
        done_count++;
      end
      if (bus.busy_o && !prev_busy) busy_cyc = cyc;
      prev_busy = bus.busy_o;
    end
  end

  typedef struct {
    int sw, sh, dw, dh, mode, hold_at, hold_len, poke_at, exp_out;
    bit chk;
    logic [31:0] e_first, e_second, e_last;
  } frame_t;

  function automatic logic [159:0] outs();
    return {bus.destx_o, bus.desty_o, bus.rd_en_o, bus.rd_addr00_o, bus.rd_addr01_o,
            bus.rd_addr10_o, bus.rd_addr11_o, bus.tvalid_o, bus.tdata00_o, bus.tdata01_o,
            bus.tdata10_o, bus.tdata11_o, bus.busy_o, bus.done_o};
  endfunction

  task automatic start_frame(input frame_t f, output int s);
    m_sw = f.sw; m_sh = f.sh; m_dw = f.dw; m_dh = f.dh; m_mode = f.mode;
    build_expected();
    tv_count = 0; rd_count = 0; got_tv.delete();
    @(posedge clk); #1;
    bus.src_width_i = IW'(f.sw); bus.src_height_i = IW'(f.sh);
    bus.dest_width_i = IW'(f.dw); bus.dest_height_i = IW'(f.dh);
    bus.start_i = 1'b1;
    s = cyc;
  endtask

  task automatic run_frame(input frame_t f);
    int s, k, budget, done0, exp_lat, exp_span, n;
    logic [IW-1:0] held_x;
    done0 = done_count;
    start_frame(f, s);
    n = f.dw * f.dh;
    budget = n + f.hold_len + 60;
    held_x = '0;
    while (done_count == done0 && budget > 0) begin
      @(posedge clk); #1;
      k = cyc - (s + 1);
      bus.start_i = (k == f.poke_at);
      if (k == f.poke_at) begin
        bus.src_width_i = 16'd9; bus.src_height_i = 16'd9;
        bus.dest_width_i = 16'd3; bus.dest_height_i = 16'd3;
      end
      bus.hold_i = (k >= f.hold_at) && (k < f.hold_at + f.hold_len);
      if (k == f.hold_at) held_x = bus.destx_o;
      if (f.hold_len > 0 && k > f.hold_at && k <= f.hold_at + f.hold_len)
        check("hold_destx_frozen", bus.destx_o, held_x);
      budget--;
    end
    bus.hold_i = 1'b0;
    bus.start_i = 1'b0;
    check("done_seen", done_count - done0, 1);
    check("busy_rise", busy_cyc, s + 1);
    check("tvalid_count", tv_count, f.exp_out);
    check("rd_en_count", rd_count, f.exp_out);
    if (f.exp_out > 0) begin
      exp_lat  = 5 + ((f.hold_at == 0) ? f.hold_len : 0);
      exp_span = n - 1 + ((f.hold_at > 0 && f.hold_at < n) ? f.hold_len : 0);
      check("first_tvalid_latency", first_tv - (s + 1), exp_lat);
      check("tvalid_span", last_tv - first_tv, exp_span);
    end
    if (f.chk && got_tv.size() >= 2) begin
      check("first_pixels", got_tv[0], f.e_first);
      check("second_pixels", got_tv[1], f.e_second);
      check("last_pixels", got_tv[got_tv.size()-1], f.e_last);
    end
  endtask

  frame_t tbl[8];
  frame_t rf;

  initial begin
    int s, snap;
    bus.start_i = 1'b0; bus.hold_i = 1'b0;
    bus.src_width_i = '0; bus.src_height_i = '0;
    bus.dest_width_i = '0; bus.dest_height_i = '0;
    m_sw = 4; m_sh = 4; m_dw = 2; m_dh = 2; m_mode = 0;
    //          sw sh dw dh md hat hln poke exp chk first         second        last
    tbl[0] = '{4, 4, 2, 2, 0, 999, 0, -1, 4, 1'b1, 32'h00010405, 32'h02030607, 32'h0a0b0e0f};
    tbl[1] = '{4, 4, 2, 2, 1, 999, 0, -1, 4, 1'b1, 32'h0506090a, 32'h07070b0b, 32'h0f0f0f0f};
    tbl[2] = '{4, 4, 2, 2, 0, 1,   3, -1, 4, 1'b1, 32'h00010405, 32'h02030607, 32'h0a0b0e0f};
    tbl[3] = '{4, 4, 0, 3, 0, 999, 0, -1, 0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{4, 4, 3, 0, 0, 999, 0, -1, 0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[5] = '{4, 4, 2, 2, 0, 999, 0, 2,  4, 1'b1, 32'h00010405, 32'h02030607, 32'h0a0b0e0f};
    tbl[6] = '{5, 3, 7, 4, 2, 0,   2, -1, 28, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[7] = '{1, 1, 3, 2, 2, 999, 0, -1, 6, 1'b1, 32'h0, 32'h0, 32'h0};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), '0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    // Reset in the middle of a frame, then a clean frame afterwards.
    rf = '{4, 4, 4, 4, 0, 999, 0, -1, 16, 1'b0, 32'h0, 32'h0, 32'h0};
    start_frame(rf, s);
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midframe_reset_outputs", outs(), '0);
    snap = done_count;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_reset", done_count, snap);
    check("idle_after_reset", bus.busy_o, 0);
    run_frame(tbl[0]);

    for (int i = 0; i < 10; i++) begin
      rf.sw = $urandom_range(1, 12); rf.sh = $urandom_range(1, 12);
      rf.dw = $urandom_range(1, 8);  rf.dh = $urandom_range(1, 6);
      rf.mode = $urandom_range(0, 2);
      rf.hold_at = $urandom_range(0, 30); rf.hold_len = $urandom_range(0, 4);
      rf.poke_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rf.dw * rf.dh - 1) : -1;
      rf.exp_out = rf.dw * rf.dh;
      rf.chk = 1'b0;
      run_frame(rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
